fpu_issue_ctrl: RTL and testbench

- Execute-stage sequencer consuming the decoder's FPU select and RegWriteF outputs.
- Issues each FP operation to the multi-cycle FPU datapath and counts its fixed latency.
- Stalls the pipeline until the result is ready, then emits a one-cycle FP register-file writeback strobe.
- Sits between the control unit outputs (registered into E) and the FPU core / FP register file.

---
 rtl/fpu_pkg.sv | 40 ++++
 rtl/fpu_issue_ctrl.sv | 109 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FP execute-stage issue logic.
//   - selFPU operation codes as produced by the decoder
//   - issue FSM state encoding
//   - fixed FPU latencies and the latency lookup used by the issue
//     controller and the hazard unit
package fpu_pkg;

  localparam int CNT_W    = 5;
  localparam int LAT_ADD  = 3;
  localparam int LAT_MUL  = 4;
  localparam int LAT_DIV  = 12;
  localparam int LAT_SQRT = 16;

  localparam logic [4:0] FPU_ADD  = 5'd0;
  localparam logic [4:0] FPU_SUB  = 5'd1;
  localparam logic [4:0] FPU_MUL  = 5'd2;
  localparam logic [4:0] FPU_DIV  = 5'd3;
  localparam logic [4:0] FPU_SQRT = 5'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fpu_state_t;

  // Cycles the FPU core needs for a given select. Moves, compares,
  // sign-injects and unlisted codes complete in a single cycle.
  function automatic logic [CNT_W-1:0] fpu_latency(input logic [4:0] sel);
    logic [CNT_W-1:0] lat;
    case (sel)
      FPU_ADD, FPU_SUB: lat = CNT_W'(LAT_ADD);
      FPU_MUL:          lat = CNT_W'(LAT_MUL);
      FPU_DIV:          lat = CNT_W'(LAT_DIV);
      FPU_SQRT:         lat = CNT_W'(LAT_SQRT);
      default:          lat = CNT_W'(1);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: execute-stage sequencer for multi-cycle FP operations.
// Accepts an FP op from E, launches the FPU core, counts its fixed latency
// on a down-counter, stalls F/D/E meanwhile, then produces a one-cycle
// FP register-file writeback strobe.
//
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   op_valid             FP instruction present in E
//   selFPU[4:0]          FPU operation select from decoder
//   RegWriteF            instruction writes the FP register file
//   rdE[4:0]             destination register
//   flush                kill the E-stage instruction
//   fpu_start            one-cycle launch pulse to the FPU core
//   fpu_sel[4:0]         captured select, held for the whole operation
//   fpu_abort            one-cycle pulse when a BUSY op is flushed
//   stall                hold F/D/E stages
//   wb_valid, wb_we      result strobe and its register-write qualifier
//   wb_rd[4:0]           captured destination register
//   op_count[15:0]       completed-operation counter (wraps)
//
// state | meaning
// IDLE  | no op in flight; accept op_valid when not flushed
// BUSY  | FPU core running; cnt holds remaining cycles
// DONE  | result ready; writeback strobe, pipeline released this cycle
module fpu_issue_ctrl
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [4:0] selFPU,
  input  logic       RegWriteF,
  input  logic [4:0] rdE,
  input  logic       flush,
  output logic       fpu_start,
  output logic [4:0] fpu_sel,
  output logic       fpu_abort,
  output logic       stall,
  output logic       wb_valid,
  output logic       wb_we,
  output logic [4:0] wb_rd,
  output logic [15:0] op_count
);

  fpu_state_t       r_state;
  fpu_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_sel;
  logic             r_we;
  logic [4:0]       r_rd;
  logic [15:0]      r_op_count;
  logic             r_start;
  logic             r_abort;

  logic             w_accept;
  logic             w_done;

  assign w_accept = (r_state == IDLE) && op_valid && !flush;
  // A flush landing in DONE kills the writeback combinationally.
  assign w_done   = (r_state == DONE) && !flush;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = BUSY;
      BUSY:    if (r_cnt <= CNT_W'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_op_count <= '0;
      r_start    <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_start <= w_accept;
      r_abort <= flush && (r_state == BUSY);
      if (w_accept) begin
        r_cnt <= fpu_latency(selFPU);
        r_sel <= selFPU;
        r_we  <= RegWriteF;
        r_rd  <= rdE;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign fpu_start = r_start;
  assign fpu_abort = r_abort;
  assign fpu_sel   = r_sel;
  assign wb_rd     = r_rd;
  assign op_count  = r_op_count;
  assign wb_valid  = w_done;
  assign wb_we     = w_done && r_we;
  // Gated by reset so the pipeline is released the instant reset rises.
  assign stall     = op_valid && (r_state != DONE) && !flush && !reset;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [4:0]  selFPU;
  logic        RegWriteF;
  logic [4:0]  rdE;
  logic        flush;
  logic        fpu_start;
  logic [4:0]  fpu_sel;
  logic        fpu_abort;
  logic        stall;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [15:0] op_count;

  int n_assert = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_wb     = 0;
  int s0;
  int w0;

  fpu_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .selFPU    (selFPU),
    .RegWriteF (RegWriteF),
    .rdE       (rdE),
    .flush     (flush),
    .fpu_start (fpu_start),
    .fpu_sel   (fpu_sel),
    .fpu_abort (fpu_abort),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fpu_start) n_start++;
    if (wb_valid)  n_wb++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; selFPU = '0; RegWriteF = 1'b0; rdE = '0; flush = 1'b0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_start", fpu_start, 0);
    chk("rst_abort", fpu_abort, 0);
    chk("rst_sel", fpu_sel, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_count", op_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // ADD, L=3: start at c1, stall c0-c3, writeback at c4
    tick; op_valid = 1; selFPU = 5'd0; RegWriteF = 1; rdE = 5'd5; #2;
    chk("add_stall_c0", stall, 1);
    chk("add_start_c0", fpu_start, 0);
    tick; #2;
    chk("add_start_c1", fpu_start, 1);
    chk("add_stall_c1", stall, 1);
    tick; #2;
    chk("add_start_c2", fpu_start, 0);
    chk("add_stall_c2", stall, 1);
    tick; #2;
    chk("add_stall_c3", stall, 1);
    chk("add_wbv_c3", wb_valid, 0);
    tick; #2;
    chk("add_wbv_c4", wb_valid, 1);
    chk("add_wbwe_c4", wb_we, 1);
    chk("add_rd_c4", wb_rd, 5);
    chk("add_stall_c4", stall, 0);
    chk("add_cnt_c4", op_count, 0);
    tick; op_valid = 0; #2;
    chk("add_wbv_c5", wb_valid, 0);
    chk("add_cnt_c5", op_count, 1);
    chk("add_noreaccept_c5", fpu_start, 0);

    // DIV (L=12) then a single-cycle op back to back
    tick; op_valid = 1; selFPU = 5'd3; RegWriteF = 1; rdE = 5'd7; s0 = n_start; #2;
    for (int c = 1; c <= 12; c++) begin
      tick; #2;
      chk($sformatf("div_stall_c%0d", c), stall, 1);
      chk($sformatf("div_wbv_c%0d", c), wb_valid, 0);
    end
    tick; #2;
    chk("div_wbv_c13", wb_valid, 1);
    chk("div_rd_c13", wb_rd, 7);
    chk("div_stall_c13", stall, 0);
    tick; selFPU = 5'd9; rdE = 5'd12; #2;
    chk("mv_wbv_c14", wb_valid, 0);
    chk("mv_stall_c14", stall, 1);
    chk("mv_rdhold_c14", wb_rd, 7);
    tick; #2;
    chk("mv_start_c15", fpu_start, 1);
    chk("mv_sel_c15", fpu_sel, 9);
    chk("mv_rd_c15", wb_rd, 12);
    tick; #2;
    chk("mv_wbv_c16", wb_valid, 1);
    chk("mv_rd_c16", wb_rd, 12);
    tick; op_valid = 0; #2;
    chk("b2b_starts", 16'(n_start - s0), 2);
    chk("b2b_cnt", op_count, 3);

    // SQRT flushed at c6
    tick; op_valid = 1; selFPU = 5'd4; RegWriteF = 1; rdE = 5'd3; w0 = n_wb; #2;
    repeat (5) tick;
    tick; flush = 1; #2;
    chk("sq_stall_flush_c6", stall, 0);
    chk("sq_wbv_c6", wb_valid, 0);
    chk("sq_abort_c6", fpu_abort, 0);
    tick; flush = 0; op_valid = 0; #2;
    chk("sq_abort_c7", fpu_abort, 1);
    chk("sq_start_c7", fpu_start, 0);
    tick; #2;
    chk("sq_abort_c8", fpu_abort, 0);
    repeat (20) tick;
    #2;
    chk("sq_no_wb", 16'(n_wb - w0), 0);
    chk("sq_cnt", op_count, 3);

    // flush in IDLE blocks acceptance and produces no abort
    tick; op_valid = 1; flush = 1; #2;
    chk("idle_flush_stall", stall, 0);
    tick; op_valid = 0; flush = 0; #2;
    chk("idle_flush_start", fpu_start, 0);
    chk("idle_flush_abort", fpu_abort, 0);

    // MUL with RegWriteF=0: wb at c5, wb_we low
    tick; op_valid = 1; selFPU = 5'd2; RegWriteF = 0; rdE = 5'd9; #2;
    repeat (4) tick;
    #2;
    chk("mul_wbv_c4", wb_valid, 0);
    tick; #2;
    chk("mul_wbv_c5", wb_valid, 1);
    chk("mul_wbwe_c5", wb_we, 0);
    chk("mul_rd_c5", wb_rd, 9);
    chk("mul_sel_c5", fpu_sel, 2);
    tick; op_valid = 0; #2;
    chk("mul_cnt", op_count, 4);

    // op_count wrap 0xFFFF -> 0
    tick; op_valid = 1; selFPU = 5'd9; RegWriteF = 1; rdE = 5'd1; #2;
    tick; #2;
    chk("wrap_start_c1", fpu_start, 1);
    chk("wrap_sel_c1", fpu_sel, 9);
    tick; #2;
    chk("wrap_wbv_c2", wb_valid, 1);
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    chk("wrap_preset", op_count, 16'hFFFF);
    tick; op_valid = 0; #2;
    chk("wrap_cnt", op_count, 16'h0000);

    // flush in DONE suppresses writeback and the count
    tick; op_valid = 1; selFPU = 5'd9; RegWriteF = 1; rdE = 5'd2; #2;
    tick;
    tick; flush = 1; #2;
    chk("dflush_wbv", wb_valid, 0);
    chk("dflush_wbwe", wb_we, 0);
    chk("dflush_stall", stall, 0);
    tick; flush = 0; op_valid = 0; #2;
    chk("dflush_cnt", op_count, 0);
    chk("dflush_abort", fpu_abort, 0);
    chk("dflush_start", fpu_start, 0);

    // reset during DIV BUSY with cnt=7 (c6)
    tick; op_valid = 1; selFPU = 5'd3; RegWriteF = 1; rdE = 5'd4; #2;
    repeat (6) tick;
    #2;
    chk("rb_stall_c6", stall, 1);
    reset = 1;
    #1;
    chk("rb_stall", stall, 0);
    chk("rb_wbv", wb_valid, 0);
    chk("rb_cnt", op_count, 0);
    chk("rb_abort", fpu_abort, 0);
    chk("rb_sel", fpu_sel, 0);
    chk("rb_rd", wb_rd, 0);
    tick; #2;
    chk("rb_abort_next", fpu_abort, 0);
    chk("rb_stall_next", stall, 0);
    reset = 0; op_valid = 0;
    tick; #2;
    chk("rb_start_after", fpu_start, 0);
    chk("rb_wbv_after", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
